// File: rtl/regdump.sv
// regdump: debug readout engine on the spare register-file read port; streams
//   registers first..last (wrapping modulo NREG) as valid/ready beats.
// Ports: clk/rst_n; start/first/last/abort control; ra/rdata read port;
//   out_valid/out_ready/out_idx/out_data beat stream; busy/done status; csum.
// Latency: 2 cycles from accepted start to first valid; one beat per 2 cycles peak.
// Backpressure: a beat is held stable in SEND until out_ready; no read is issued meanwhile.
// Optional feature: define REGDUMP_CSUM_EN to build the XOR checksum of emitted
//   beats; otherwise csum is tied to 0.
module regdump #(
  parameter int NREG = 32,
  parameter int DW   = 32,
  localparam int IW  = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [IW-1:0] first,
  input  logic [IW-1:0] last,
  input  logic          abort,
  output logic [IW-1:0] ra,
  input  logic [DW-1:0] rdata,
  output logic          busy,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [IW-1:0] out_idx,
  output logic [DW-1:0] out_data,
  output logic          done,
  output logic [DW-1:0] csum
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] end_q, end_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [DW-1:0] data_q, data_d;
  logic          done_q, done_d;
  logic [IW-1:0] ptr_inc;

  // Explicit wrap so a non-power-of-two NREG still cycles through 0..NREG-1.
  assign ptr_inc = (ptr_q == IW'(NREG - 1)) ? '0 : ptr_q + 1'b1;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    end_d   = end_q;
    idx_d   = idx_q;
    data_d  = data_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          ptr_d   = first;
          end_d   = last;
          state_d = READ;
        end
      end
      READ: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          // rdata is combinational on ra (== ptr_q); capture it at this edge.
          idx_d   = ptr_q;
          data_d  = rdata;
          state_d = SEND;
        end
      end
      SEND: begin
        // abort takes priority over a completing handshake: no done pulse.
        if (abort) begin
          state_d = IDLE;
        end else if (out_ready) begin
          if (ptr_q == end_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            ptr_d   = ptr_inc;
            state_d = READ;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      end_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      end_q   <= end_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  assign ra        = ptr_q;
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == SEND);
  assign out_idx   = idx_q;
  assign out_data  = data_q;
  assign done      = done_q;

`ifdef REGDUMP_CSUM_EN
  logic [DW-1:0] csum_q, csum_d;
  logic          start_acc;
  logic          beat_acc;

  assign start_acc = (state_q == IDLE) && start;
  // Aborted handshakes do not contribute to the checksum.
  assign beat_acc  = (state_q == SEND) && out_ready && !abort;

  always_comb begin
    csum_d = csum_q;
    if (start_acc) begin
      csum_d = '0;
    end else if (beat_acc) begin
      csum_d = csum_q ^ data_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign csum = csum_q;
`else
  assign csum = '0;
`endif

endmodule

// File: tb/tb_regdump.sv
module tb_regdump;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [4:0]  first;
  logic [4:0]  last;
  logic        abort;
  logic [4:0]  ra;
  logic [31:0] rdata;
  logic        busy;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_idx;
  logic [31:0] out_data;
  logic        done;
  logic [31:0] csum;

  logic [31:0] regs [32];
  int errors;
  int checks;

  regdump #(.NREG(32), .DW(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .first     (first),
    .last      (last),
    .abort     (abort),
    .ra        (ra),
    .rdata     (rdata),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_data  (out_data),
    .done      (done),
    .csum      (csum)
  );

  // Register file model: combinational read.
  assign rdata = regs[ra];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] csum_model(input logic [31:0] x);
`ifdef REGDUMP_CSUM_EN
    return x;
`else
    return 32'h0;
`endif
  endfunction

  // Runs one dump from first=f to last=l. hold<0 selects a random 0..3 ready-low
  // stall per beat. abort_beat selects the beat whose SEND is aborted (with ready
  // high in the same cycle); -1 means no abort. b2b leaves the task in the done
  // cycle so the next dump's start lands there.
  task automatic run_dump(input int f, input int l, input int hold,
                          input int abort_beat, input bit b2b);
    int n;
    int waited;
    int h;
    logic [4:0]  idx;
    logic [31:0] exp_d;
    logic [31:0] exp_c;
    n = ((l - f + 32) % 32) + 1;
    exp_c = 32'h0;
    check("idle_busy", busy, 1'b0);
    start = 1'b1;
    first = f[4:0];
    last  = l[4:0];
    step();
    start = 1'b0;
    first = 5'($urandom);
    last  = 5'($urandom);
    check("start_busy", busy, 1'b1);
    check("start_ra", ra, f[4:0]);
    check("start_done_clear", done, 1'b0);
    check("start_valid_low", out_valid, 1'b0);
    for (int k = 0; k < n; k++) begin
      idx   = 5'((f + k) % 32);
      exp_d = regs[idx];
      start = 1'($urandom % 2);          // ignored while busy
      waited = 0;
      do begin
        step();
        waited++;
      end while (!out_valid && waited < 8);
      start = 1'b0;
      check("beat_latency", waited, 1);
      check("beat_valid", out_valid, 1'b1);
      check("beat_idx", out_idx, idx);
      check("beat_data", out_data, exp_d);
      check("beat_ra", ra, idx);
      h = (hold < 0) ? $urandom_range(0, 3) : hold;
      for (int j = 0; j < h; j++) begin
        out_ready = 1'b0;
        start = 1'($urandom % 2);
        regs[idx] = $urandom;            // captured beat must not follow the regfile
        step();
        check("hold_valid", out_valid, 1'b1);
        check("hold_idx", out_idx, idx);
        check("hold_data", out_data, exp_d);
      end
      start = 1'b0;
      if (k == abort_beat) begin
        abort = 1'b1;
        out_ready = 1'b1;
        step();
        abort = 1'b0;
        out_ready = 1'b0;
        check("abort_valid", out_valid, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_csum", csum, csum_model(exp_c));
        step();
        check("abort_done_late", done, 1'b0);
        return;
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      exp_c = exp_c ^ exp_d;
      if (k == n - 1) begin
        check("done_pulse", done, 1'b1);
        check("done_busy", busy, 1'b0);
        check("done_valid", out_valid, 1'b0);
        check("done_csum", csum, csum_model(exp_c));
        check("done_ra", ra, idx);
        if (!b2b) begin
          step();
          check("done_clear", done, 1'b0);
          check("csum_hold", csum, csum_model(exp_c));
          check("ra_hold", ra, idx);
        end
      end else begin
        check("mid_valid", out_valid, 1'b0);
        check("mid_done", done, 1'b0);
        check("mid_busy", busy, 1'b1);
      end
    end
  endtask

  initial begin
    int f;
    int l;
    int ab;
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    start = 1'b0;
    first = '0;
    last  = '0;
    abort = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 32; i++) regs[i] = i * 32'h11111111;

    #2;
    check("rst_busy", busy, 1'b0);
    check("rst_valid", out_valid, 1'b0);
    check("rst_idx", out_idx, 5'd0);
    check("rst_data", out_data, 32'h0);
    check("rst_done", done, 1'b0);
    check("rst_ra", ra, 5'd0);
    check("rst_csum", csum, 32'h0);
    #10;
    rst_n = 1'b1;
    step();

    // Directed cases from the regfile pattern reg[i] = i*0x11111111.
    run_dump(3, 5, 0, -1, 1'b0);
    run_dump(30, 1, 0, -1, 1'b1);      // wrap; next start lands in done cycle
    run_dump(7, 7, 5, -1, 1'b0);       // single beat under 5-cycle stall
    run_dump(0, 9, 0, 1, 1'b0);        // abort during second beat's SEND
    run_dump(0, 0, 0, -1, 1'b0);

    // Abort while in READ.
    start = 1'b1; first = 5'd10; last = 5'd12;
    step();
    start = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("rdabort_busy", busy, 1'b0);
    check("rdabort_valid", out_valid, 1'b0);
    check("rdabort_done", done, 1'b0);
    step();
    check("rdabort_done_late", done, 1'b0);
    abort = 1'b1;                      // abort in IDLE has no effect
    step();
    abort = 1'b0;
    check("idle_abort_busy", busy, 1'b0);

    // Asynchronous reset in the middle of the second READ.
    start = 1'b1; first = 5'd20; last = 5'd25;
    step();
    start = 1'b0;
    step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_valid", out_valid, 1'b0);
    check("arst_idx", out_idx, 5'd0);
    check("arst_data", out_data, 32'h0);
    check("arst_done", done, 1'b0);
    check("arst_ra", ra, 5'd0);
    check("arst_csum", csum, 32'h0);
    #1;
    rst_n = 1'b1;
    step();
    check("arst_stay_idle", busy, 1'b0);

    // Randomized dumps against the index/value model.
    for (int r = 0; r < 14; r++) begin
      for (int i = 0; i < 32; i++) regs[i] = $urandom;
      f  = $urandom_range(0, 31);
      l  = $urandom_range(0, 31);
      ab = ($urandom % 4 == 0) ? $urandom_range(0, 5) : -1;
      run_dump(f, l, -1, ab, 1'($urandom % 2));
    end
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
